// File: rtl/rv_pkg.sv
// Constants shared by the RV32 fetch and decode stages.
package rv_pkg;

    localparam int          PC_W = 16;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;

    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush; storage is left unreset, only pointers and count.
module ifetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    always_comb begin
        do_push = push_i && !flush_i;
        do_pop  = pop_i && !flush_i && !empty_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: credit-limited in-order word fetch, buffered responses,
// a registered decode-facing slot and redirect flush with stale-response dropping.
module ifetch_unit #(
    parameter int              PC_W     = rv_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2,
    parameter logic [31:0]     NOP      = rv_pkg::NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instruction,
    output logic            instr_valid,
    input  logic            decode_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
);
    import rv_pkg::*;

    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = PC_W + 32;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic            out_vld_q, out_vld_d, first_q;
    logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d;
    logic            rv, discard, keep, accept, pop, slot_free;
    logic            dat_push, dat_pop, dat_full, dat_empty, tag_full, tag_empty;
    logic [CW-1:0]   dat_cnt, tag_cnt;
    logic [DW-1:0]   dat_head;
    logic [PC_W-1:0] tag_head;

    assign pc          = out_pc_q;
    assign instruction = out_instr_q;
    assign instr_valid = out_vld_q;

    // Responses in the first cycle after reset release belong to pre-reset requests.
    always_comb begin
        rv        = imem_rvalid && !first_q;
        imem_req  = rst_n && !redirect_valid &&
                    (({1'b0, dat_cnt} + {1'b0, outst_q}) < (CW+1)'(DEPTH));
        imem_addr = fetch_pc_q;
        accept    = imem_req && imem_gnt;
        keep      = rv && !discard && !redirect_valid;
        pop       = out_vld_q && decode_ready;
        slot_free = !out_vld_q || pop;
        dat_pop   = slot_free && !dat_empty && !redirect_valid;
        dat_push  = keep && !(slot_free && dat_empty);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(accept) - CW'(rv);
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            drop_d     = outst_q - CW'(rv);
        end else begin
            if (accept)        fetch_pc_d = fetch_pc_q + PC_W'(4);
            if (rv && discard) drop_d     = drop_q - CW'(1);
        end
    end

    // The output slot sits in front of the FIFO; a response bypasses into it when both are free.
    always_comb begin
        out_vld_d   = out_vld_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        if (redirect_valid) begin
            out_vld_d   = 1'b0;
            out_instr_d = NOP;
        end else if (slot_free) begin
            if (!dat_empty) begin
                out_vld_d               = 1'b1;
                {out_pc_d, out_instr_d} = dat_head;
            end else if (keep) begin
                out_vld_d   = 1'b1;
                out_pc_d    = tag_head;
                out_instr_d = imem_rdata;
            end else begin
                out_vld_d   = 1'b0;
                out_instr_d = NOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FS_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_RUN:   if (redirect_valid && drop_d != '0) state_d = FS_FLUSH;
            FS_FLUSH: if (drop_d == '0)                   state_d = FS_RUN;
            default:                                      state_d = FS_RUN;
        endcase
    end

    always_comb discard = (state_q == FS_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            outst_q     <= '0;
            drop_q      <= '0;
            out_vld_q   <= 1'b0;
            out_pc_q    <= RESET_PC;
            out_instr_q <= NOP;
            first_q     <= 1'b1;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            out_vld_q   <= out_vld_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            first_q     <= 1'b0;
        end
    end

    ifetch_fifo #(.WIDTH(DW), .DEPTH(DEPTH)) u_dat_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(dat_push), .data_i({tag_head, imem_rdata}),
        .pop_i(dat_pop), .flush_i(redirect_valid), .data_o(dat_head), .count_o(dat_cnt),
        .full_o(dat_full), .empty_o(dat_empty)
    );

    ifetch_fifo #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(accept), .data_i(fetch_pc_q),
        .pop_i(keep), .flush_i(redirect_valid), .data_o(tag_head), .count_o(tag_cnt),
        .full_o(tag_full), .empty_o(tag_empty)
    );

    a_rvalid_outst: assert property (@(posedge clk) disable iff (!rst_n) rv |-> (outst_q != '0))
        else $error("imem_rvalid with no outstanding fetch");
    a_tag_balance: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, tag_cnt} + {1'b0, drop_q}) == {1'b0, outst_q})
        else $error("tag count and drop count do not cover outstanding fetches");
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dat_push && dat_full && !dat_pop) && !(accept && tag_full) && !(keep && tag_empty))
        else $error("fetch buffer overflow or untagged response");

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed per-cycle vector bench for ifetch_unit with a hand-written reset-in-flight sequence.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [15:0] imem_addr, pc, redirect_pc;
    logic [31:0] imem_rdata, instruction;
    logic        instr_valid, decode_ready, redirect_valid;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    always #5 clk = ~clk;

    ifetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .DEPTH(2), .NOP(NOP_W)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc(pc), .instruction(instruction), .instr_valid(instr_valid),
        .decode_ready(decode_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_vld;
        logic [15:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic check_outs(input int cyc, input logic e_req, input logic [15:0] e_addr,
                              input logic e_vld, input logic [15:0] e_pc, input logic [31:0] e_instr);
        chk("imem_req", cyc, {31'd0, imem_req}, {31'd0, e_req});
        chk("imem_addr", cyc, {16'd0, imem_addr}, {16'd0, e_addr});
        chk("instr_valid", cyc, {31'd0, instr_valid}, {31'd0, e_vld});
        chk("pc", cyc, {16'd0, pc}, {16'd0, e_pc});
        chk("instruction", cyc, instruction, e_instr);
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic rdy, input logic redir, input logic [15:0] rpc);
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rdata;
        decode_ready   = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic add(input logic gnt, input logic rv, input logic [31:0] rdata, input logic rdy,
                       input logic redir, input logic [15:0] rpc, input logic e_req,
                       input logic [15:0] e_addr, input logic e_vld, input logic [15:0] e_pc,
                       input logic [31:0] e_instr);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    initial begin
        // Sequential fetch with 1-cycle memory, decode always ready.
        add(1,0,32'h0,1,0,16'h0,         1,16'h0000,0,16'h0000,NOP_W);
        add(1,1,32'h00500093,1,0,16'h0,  1,16'h0004,0,16'h0000,NOP_W);
        add(1,1,32'h00100113,1,0,16'h0,  1,16'h0008,1,16'h0000,32'h00500093);
        add(0,1,32'h002081B3,1,0,16'h0,  1,16'h000C,1,16'h0004,32'h00100113);
        add(0,0,32'h0,1,0,16'h0,         1,16'h000C,1,16'h0008,32'h002081B3);
        // Decode stall: credits run out, head held, resume without loss.
        add(1,0,32'h0,1,0,16'h0,         1,16'h000C,0,16'h0008,NOP_W);
        add(1,1,32'hAA00000C,0,0,16'h0,  1,16'h0010,0,16'h0008,NOP_W);
        add(1,1,32'hAA000010,0,0,16'h0,  1,16'h0014,1,16'h000C,32'hAA00000C);
        add(1,1,32'hAA000014,0,0,16'h0,  0,16'h0018,1,16'h000C,32'hAA00000C);
        add(1,0,32'h0,0,0,16'h0,         0,16'h0018,1,16'h000C,32'hAA00000C);
        add(1,0,32'h0,1,0,16'h0,         0,16'h0018,1,16'h000C,32'hAA00000C);
        add(1,0,32'h0,1,0,16'h0,         1,16'h0018,1,16'h0010,32'hAA000010);
        add(0,1,32'hAA000018,1,0,16'h0,  1,16'h001C,1,16'h0014,32'hAA000014);
        add(0,0,32'h0,1,0,16'h0,         1,16'h001C,1,16'h0018,32'hAA000018);
        // Redirect to 0x0103 with two fetches outstanding.
        add(1,0,32'h0,1,0,16'h0,         1,16'h001C,0,16'h0018,NOP_W);
        add(1,0,32'h0,1,0,16'h0,         1,16'h0020,0,16'h0018,NOP_W);
        add(1,0,32'h0,1,1,16'h0103,      0,16'h0024,0,16'h0018,NOP_W);
        add(1,1,32'hDEAD0001,1,0,16'h0,  0,16'h0100,0,16'h0018,NOP_W);
        add(1,1,32'hDEAD0002,1,0,16'h0,  1,16'h0100,0,16'h0018,NOP_W);
        add(0,1,32'h00A00513,1,0,16'h0,  1,16'h0104,0,16'h0018,NOP_W);
        add(0,0,32'h0,1,0,16'h0,         1,16'h0104,1,16'h0100,32'h00A00513);
        // Redirect together with a response and a pop.
        add(1,0,32'h0,1,0,16'h0,         1,16'h0104,0,16'h0100,NOP_W);
        add(1,1,32'h11110104,1,0,16'h0,  1,16'h0108,0,16'h0100,NOP_W);
        add(1,0,32'h0,0,0,16'h0,         1,16'h010C,1,16'h0104,32'h11110104);
        add(1,1,32'h22220108,1,1,16'h0202, 0,16'h0110,1,16'h0104,32'h11110104);
        add(1,1,32'h3333010C,1,0,16'h0,  1,16'h0200,0,16'h0104,NOP_W);
        add(0,1,32'h44440200,1,0,16'h0,  1,16'h0204,0,16'h0104,NOP_W);
        add(0,0,32'h0,1,0,16'h0,         1,16'h0204,1,16'h0200,32'h44440200);
        // Redirect near the top of the address space; fetch and pc wrap to 0.
        add(0,0,32'h0,1,1,16'hFFF8,      0,16'h0204,0,16'h0200,NOP_W);
        add(1,0,32'h0,1,0,16'h0,         1,16'hFFF8,0,16'h0200,NOP_W);
        add(1,1,32'h5555FFF8,1,0,16'h0,  1,16'hFFFC,0,16'h0200,NOP_W);
        add(1,1,32'h6666FFFC,1,0,16'h0,  1,16'h0000,1,16'hFFF8,32'h5555FFF8);
        add(0,1,32'h77770000,1,0,16'h0,  1,16'h0004,1,16'hFFFC,32'h6666FFFC);
        add(0,0,32'h0,1,0,16'h0,         1,16'h0004,1,16'h0000,32'h77770000);
        add(0,0,32'h0,1,0,16'h0,         1,16'h0004,0,16'h0000,NOP_W);
        // Build up two fetches in flight with a word presented, ahead of a reset.
        add(1,0,32'h0,0,0,16'h0,         1,16'h0004,0,16'h0000,NOP_W);
        add(1,0,32'h0,0,0,16'h0,         1,16'h0008,0,16'h0000,NOP_W);
        add(1,1,32'h88880004,0,0,16'h0,  0,16'h000C,0,16'h0000,NOP_W);
        add(1,0,32'h0,0,0,16'h0,         1,16'h000C,1,16'h0004,32'h88880004);

        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 16'h0);
        @(negedge clk);
        #1;
        check_outs(-1, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP_W);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            #1;
            check_outs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld, vecs[i].e_pc, vecs[i].e_instr);
            @(negedge clk);
        end

        // Reset asserted mid-cycle with fetches to 0x0008 and 0x000C in flight.
        drive(0, 0, 32'h0, 0, 0, 16'h0);
        #1;
        check_outs(100, 1'b0, 16'h0010, 1'b1, 16'h0004, 32'h88880004);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs(101, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP_W);
        @(negedge clk);
        drive(0, 1, 32'hDEAD0008, 1, 0, 16'h0);
        #1;
        check_outs(102, 1'b0, 16'h0000, 1'b0, 16'h0000, NOP_W);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 32'hDEAD000C, 1, 0, 16'h0);
        #1;
        check_outs(103, 1'b1, 16'h0000, 1'b0, 16'h0000, NOP_W);
        @(negedge clk);
        drive(1, 0, 32'h0, 1, 0, 16'h0);
        #1;
        check_outs(104, 1'b1, 16'h0000, 1'b0, 16'h0000, NOP_W);
        @(negedge clk);
        drive(0, 1, 32'h0BEE0000, 1, 0, 16'h0);
        #1;
        check_outs(105, 1'b1, 16'h0004, 1'b0, 16'h0000, NOP_W);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 16'h0);
        #1;
        check_outs(106, 1'b1, 16'h0004, 1'b1, 16'h0000, 32'h0BEE0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
